// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory addressing and
// the IF/ID pipeline register with stall, flush, branch and exception redirect.
module fetch_stage #(
    parameter int          N          = 64,
    parameter int          IMEM_DEPTH = 128,
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [63:0] EXC_VECTOR = 64'hD8,
    parameter logic [31:0] NOP        = 32'h8b1f03ff
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall_f,
    input  logic         flush_d,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         exc_taken,
    output logic [6:0]   imem_addr,
    input  logic [31:0]  imem_q,
    output logic [N-1:0] pc_f,
    output logic [31:0]  instr_d,
    output logic [N-1:0] pc_d,
    output logic         valid_d,
    output logic         fetch_exc_d
);

    localparam logic [N-1:0] PC_LIMIT = N'(4 * IMEM_DEPTH);
    localparam logic [N-1:0] PC_STEP  = N'(4);

    logic [N-1:0] pc_reg, pc_next;
    logic [31:0]  instr_reg, instr_next;
    logic [N-1:0] pcd_reg, pcd_next;
    logic         valid_reg, valid_next;
    logic         exc_reg, exc_next;
    logic         bad;
    logic         redirect;

    // Out-of-range fetches still drive the memory address; the word is simply discarded.
    assign bad       = (pc_reg[1:0] != 2'b00) || (pc_reg >= PC_LIMIT);
    assign redirect  = exc_taken || branch_taken;
    assign imem_addr = pc_reg[8:2];

    always_comb begin
        pc_next = pc_reg + PC_STEP;
        if (exc_taken)
            pc_next = EXC_VECTOR[N-1:0];
        else if (branch_taken)
            pc_next = branch_target;
        else if (stall_f)
            pc_next = pc_reg;
    end

    // A redirect squashes the wrong-path fetch even while stalled; pc_d is left alone on bubbles.
    always_comb begin
        instr_next = instr_reg;
        pcd_next   = pcd_reg;
        valid_next = valid_reg;
        exc_next   = exc_reg;
        if (redirect || flush_d) begin
            instr_next = NOP;
            valid_next = 1'b0;
            exc_next   = 1'b0;
        end else if (!stall_f) begin
            pcd_next   = pc_reg;
            instr_next = bad ? NOP : imem_q;
            valid_next = 1'b1;
            exc_next   = bad;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg    <= RESET_PC[N-1:0];
            instr_reg <= NOP;
            pcd_reg   <= '0;
            valid_reg <= 1'b0;
            exc_reg   <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            pcd_reg   <= pcd_next;
            valid_reg <= valid_next;
            exc_reg   <= exc_next;
        end
    end

    assign pc_f        = pc_reg;
    assign instr_d     = instr_reg;
    assign pc_d        = pcd_reg;
    assign valid_d     = valid_reg;
    assign fetch_exc_d = exc_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, randomized run
// against a behavioural model, and an asynchronous mid-stream reset.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h8b1f03ff;
    localparam logic [63:0] EXC = 64'hD8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_f = 1'b0, flush_d = 1'b0, branch_taken = 1'b0, exc_taken = 1'b0;
    logic [63:0] branch_target = '0;
    logic [6:0]  imem_addr;
    logic [31:0] imem_q;
    logic [63:0] pc_f, pc_d;
    logic [31:0] instr_d;
    logic        valid_d, fetch_exc_d;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall_f(stall_f), .flush_d(flush_d),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .exc_taken(exc_taken), .imem_addr(imem_addr), .imem_q(imem_q),
        .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
        .fetch_exc_d(fetch_exc_d)
    );

    always #5 clk = ~clk;
    assign imem_q = 32'hC0DE0000 | {25'b0, imem_addr};

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        stall, flush, br, exc;
        logic [63:0] tgt;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic [63:0] e_pcd;
        logic        e_v, e_e;
    } vec_t;

    vec_t vt[21];

    function automatic vec_t mk(logic s, logic f, logic b, logic x, logic [63:0] t,
                                logic [63:0] pc, logic [31:0] ins, logic [63:0] pcd,
                                logic v, logic e);
        vec_t r;
        r.stall = s; r.flush = f; r.br = b; r.exc = x; r.tgt = t;
        r.e_pc = pc; r.e_instr = ins; r.e_pcd = pcd; r.e_v = v; r.e_e = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [63:0] e_pc, input logic [31:0] e_instr,
                           input logic [63:0] e_pcd, input logic e_v, input logic e_e);
        logic [63:0] a;
        a = e_pc;
        $display("txn %s pc_f=%h imem_addr=%h instr_d=%h pc_d=%h valid_d=%b fetch_exc_d=%b",
                 tag, pc_f, imem_addr, instr_d, pc_d, valid_d, fetch_exc_d);
        chk({tag, ".pc_f"}, pc_f, e_pc);
        chk({tag, ".imem_addr"}, {57'b0, imem_addr}, {57'b0, a[8:2]});
        chk({tag, ".instr_d"}, {32'b0, instr_d}, {32'b0, e_instr});
        chk({tag, ".pc_d"}, pc_d, e_pcd);
        chk({tag, ".valid_d"}, {63'b0, valid_d}, {63'b0, e_v});
        chk({tag, ".fetch_exc_d"}, {63'b0, fetch_exc_d}, {63'b0, e_e});
    endtask

    task automatic drive(input logic s, input logic f, input logic b, input logic x, input logic [63:0] t);
        stall_f = s; flush_d = f; branch_taken = b; exc_taken = x; branch_target = t;
    endtask

    // Behavioural model: architectural PC plus one IF/ID slot.
    logic [63:0] m_pc, m_pcd;
    logic [31:0] m_instr;
    logic        m_v, m_e;

    function automatic logic [31:0] mem_word(logic [63:0] pc);
        return 32'hC0DE0000 + 32'((pc / 4) % 128);
    endfunction

    task automatic model_step(input logic s, input logic f, input logic b, input logic x, input logic [63:0] t);
        logic fault;
        fault = (pc_mod4(m_pc) != 0) || (m_pc > 64'd511);
        if (x || b || f) begin
            m_instr = NOP; m_v = 1'b0; m_e = 1'b0;
        end else if (!s) begin
            m_pcd = m_pc; m_v = 1'b1; m_e = fault;
            m_instr = fault ? NOP : mem_word(m_pc);
        end
        if (x)      m_pc = EXC;
        else if (b) m_pc = t;
        else if (!s) m_pc = m_pc + 64'd4;
    endtask

    function automatic int pc_mod4(logic [63:0] pc);
        return int'(pc % 4);
    endfunction

    initial begin
        vt[0]  = mk(0,0,0,0, 64'h0,   64'h4,   32'hC0DE0000, 64'h0,   1, 0);
        vt[1]  = mk(0,0,0,0, 64'h0,   64'h8,   32'hC0DE0001, 64'h4,   1, 0);
        vt[2]  = mk(0,0,0,0, 64'h0,   64'hC,   32'hC0DE0002, 64'h8,   1, 0);
        vt[3]  = mk(0,0,0,0, 64'h0,   64'h10,  32'hC0DE0003, 64'hC,   1, 0);
        vt[4]  = mk(1,0,0,0, 64'h0,   64'h10,  32'hC0DE0003, 64'hC,   1, 0);
        vt[5]  = mk(1,0,0,0, 64'h0,   64'h10,  32'hC0DE0003, 64'hC,   1, 0);
        vt[6]  = mk(0,0,0,0, 64'h0,   64'h14,  32'hC0DE0004, 64'h10,  1, 0);
        vt[7]  = mk(0,0,1,0, 64'h40,  64'h40,  NOP,          64'h10,  0, 0);
        vt[8]  = mk(0,0,0,0, 64'h0,   64'h44,  32'hC0DE0010, 64'h40,  1, 0);
        vt[9]  = mk(1,0,1,1, 64'h100, 64'hD8,  NOP,          64'h40,  0, 0);
        vt[10] = mk(0,0,0,0, 64'h0,   64'hDC,  32'hC0DE0036, 64'hD8,  1, 0);
        vt[11] = mk(0,0,1,0, 64'h1FC, 64'h1FC, NOP,          64'hD8,  0, 0);
        vt[12] = mk(0,0,0,0, 64'h0,   64'h200, 32'hC0DE007F, 64'h1FC, 1, 0);
        vt[13] = mk(0,0,0,0, 64'h0,   64'h204, NOP,          64'h200, 1, 1);
        vt[14] = mk(0,0,1,0, 64'h42,  64'h42,  NOP,          64'h200, 0, 0);
        vt[15] = mk(0,0,0,0, 64'h0,   64'h46,  NOP,          64'h42,  1, 1);
        vt[16] = mk(1,1,0,0, 64'h0,   64'h46,  NOP,          64'h42,  0, 0);
        vt[17] = mk(0,1,0,0, 64'h0,   64'h4A,  NOP,          64'h42,  0, 0);
        vt[18] = mk(0,0,1,0, 64'h0,   64'h0,   NOP,          64'h42,  0, 0);
        vt[19] = mk(0,0,1,0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, NOP, 64'h42, 0, 0);
        vt[20] = mk(0,0,0,0, 64'h0,   64'h0,   NOP, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1);

        #2 reset = 1'b0;
        #1 chk_all("reset", 64'h0, NOP, 64'h0, 0, 0);
        @(posedge clk); #1;
        chk_all("reset_held", 64'h0, NOP, 64'h0, 0, 0);
        @(negedge clk) reset = 1'b1;

        for (int i = 0; i < 21; i++) begin
            drive(vt[i].stall, vt[i].flush, vt[i].br, vt[i].exc, vt[i].tgt);
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_instr, vt[i].e_pcd, vt[i].e_v, vt[i].e_e);
        end
        drive(0, 0, 0, 0, 64'h0);

        m_pc = pc_f; m_pcd = 64'hFFFF_FFFF_FFFF_FFFC; m_instr = NOP; m_v = 1'b1; m_e = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic s, f, b, x;
            logic [63:0] t;
            int sel;
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 9) == 0);
            b = ($urandom_range(0, 9) == 0);
            x = ($urandom_range(0, 19) == 0);
            sel = $urandom_range(0, 3);
            if (sel == 0)      t = 64'($urandom_range(0, 127)) * 4;
            else if (sel == 1) t = 64'($urandom_range(0, 511));
            else if (sel == 2) t = 64'h1F0 + 64'($urandom_range(0, 7)) * 4;
            else               t = {32'($urandom), 32'($urandom)};
            drive(s, f, b, x, t);
            model_step(s, f, b, x, t);
            @(posedge clk); #1;
            chk_all($sformatf("rnd%0d", i), m_pc, m_instr, m_pcd, m_v, m_e);
        end
        drive(0, 0, 0, 0, 64'h0);

        #3 reset = 1'b0;
        #1 chk_all("async_reset", 64'h0, NOP, 64'h0, 0, 0);
        @(posedge clk); #1;
        chk_all("async_reset_held", 64'h0, NOP, 64'h0, 0, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk_all("restart0", 64'h4, 32'hC0DE0000, 64'h0, 1, 0);
        @(posedge clk); #1;
        chk_all("restart1", 64'h8, 32'hC0DE0001, 64'h4, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
